// File: rtl/fillscreen_pattern.sv
// Column-major framebuffer sweep that plots one pixel per accepted cycle.
// The pixel colour comes from a pattern mode that is latched together with the base colour at start.
module fillscreen_pattern #(
    parameter int unsigned WIDTH    = 160,
    parameter int unsigned HEIGHT   = 120,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                plot_ready,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

    state_e              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d, nx;
    logic [Y_W-1:0]      y_q, y_d, ny;
    logic [COLOUR_W-1:0] pix_q, pix_d, col_lat_q, col_lat_d;
    logic [1:0]          mode_q, mode_d;
    logic                accept, last_px;

    function automatic logic [COLOUR_W-1:0] pattern(input logic [1:0]          m,
                                                    input logic [COLOUR_W-1:0] c,
                                                    input logic [X_W-1:0]      px,
                                                    input logic [Y_W-1:0]      py);
        case (m)
            2'd0:    return c;
            2'd1:    return COLOUR_W'(px);
            2'd2:    return COLOUR_W'(py);
            default: return (px[0] ^ py[0]) ? ~c : c;
        endcase
    endfunction

    assign accept  = (state_q == FILL) && plot_ready;
    assign last_px = (x_q == X_W'(WIDTH - 1)) && (y_q == Y_W'(HEIGHT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (accept && last_px) state_d = DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vga_x      = x_q;
        vga_y      = y_q;
        vga_colour = pix_q;
        vga_plot   = (state_q == FILL);
        busy       = (state_q == FILL);
        done       = (state_q == DONE);
    end

    // The colour of the next pixel is computed here, so it is registered with its coordinates.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        pix_d     = pix_q;
        mode_d    = mode_q;
        col_lat_d = col_lat_q;
        nx        = x_q;
        if (y_q == Y_W'(HEIGHT - 1)) begin
            ny = '0;
            nx = x_q + X_W'(1);
        end else begin
            ny = y_q + Y_W'(1);
        end
        if (state_q == IDLE && start) begin
            mode_d    = mode;
            col_lat_d = colour;
            x_d       = '0;
            y_d       = '0;
            pix_d     = pattern(mode, colour, '0, '0);
        end else if (accept && !last_px) begin
            x_d   = nx;
            y_d   = ny;
            pix_d = pattern(mode_q, col_lat_q, nx, ny);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            pix_q     <= '0;
            mode_q    <= '0;
            col_lat_q <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            pix_q     <= pix_d;
            mode_q    <= mode_d;
            col_lat_q <= col_lat_d;
        end
    end

endmodule

// File: tb/tb_fillscreen_pattern.sv
// Randomised bench for fillscreen_pattern at the default geometry and at an 8x4 geometry.
// Each observed pixel is compared with the sweep order and colour rules, using k/HEIGHT and k%HEIGHT.
module tb_fillscreen_pattern;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       plot_ready = 1'b0;
    logic       sel = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] colour = 8'd0;

    logic [7:0] a_x;
    logic [6:0] a_y;
    logic [2:0] a_col;
    logic       a_plot, a_busy, a_done;
    logic [2:0] b_x;
    logic [1:0] b_y;
    logic [1:0] b_col;
    logic       b_plot, b_busy, b_done;

    logic [63:0] obs;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fillscreen_pattern dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .mode(mode),
        .colour(colour[2:0]), .plot_ready(plot_ready),
        .vga_x(a_x), .vga_y(a_y), .vga_colour(a_col), .vga_plot(a_plot),
        .busy(a_busy), .done(a_done)
    );

    fillscreen_pattern #(.WIDTH(8), .HEIGHT(4), .X_W(3), .Y_W(2), .COLOUR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .mode(mode),
        .colour(colour[1:0]), .plot_ready(plot_ready),
        .vga_x(b_x), .vga_y(b_y), .vga_colour(b_col), .vga_plot(b_plot),
        .busy(b_busy), .done(b_done)
    );

    // Layout: bit 42 done, bit 41 busy, bit 40 plot, x[39:24], y[23:8], colour[7:0].
    function automatic logic [63:0] pk(input logic d, input logic b, input logic p,
                                       input int x, input int y, input int c);
        return {21'b0, d, b, p, x[15:0], y[15:0], c[7:0]};
    endfunction

    function automatic int exp_col(input int md, input int col, input int x, input int y, input int cw);
        int m, c;
        m = 1 << cw;
        c = col % m;
        case (md)
            0:       return c;
            1:       return x % m;
            2:       return y % m;
            default: return ((x + y) % 2 == 0) ? c : (m - 1 - c);
        endcase
    endfunction

    always_comb begin
        if (sel) obs = pk(b_done, b_busy, b_plot, int'(b_x), int'(b_y), int'(b_col));
        else     obs = pk(a_done, a_busy, a_plot, int'(a_x), int'(a_y), int'(a_col));
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int cw,
                             input int md, input int col, input int pct,
                             input bit disturb, input int abort_k);
        int k, cyc, limit, n;
        bit rdy;
        n = w * h;
        mode = md[1:0];
        colour = col[7:0];
        start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        cyc = 1;
        limit = (pct >= 100) ? n + 2 : n * 20 + 10;
        while (!obs[42] && cyc <= limit) begin
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check_eq({tag, "_rst_outputs"}, obs, 64'd0);
                return;
            end
            check_eq({tag, "_pixel"}, obs,
                     pk(1'b0, 1'b1, 1'b1, k / h, k % h, exp_col(md, col, k / h, k % h, cw)));
            rdy = ($urandom_range(99) < pct);
            plot_ready = rdy;
            if (disturb) begin
                mode = 2'($urandom);
                colour = 8'($urandom);
                if (cyc == 2) start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (rdy) k++;
        end
        check_eq({tag, "_done_flags"}, 64'(obs[42:40]), 64'(3'b100));
        check_eq({tag, "_accepted"}, 64'(k), 64'(n));
        if (pct >= 100) check_eq({tag, "_done_cycle"}, 64'(cyc), 64'(n + 1));
        if (start) begin
            repeat (2) begin
                @(posedge clk); #1;
                check_eq({tag, "_done_hold"}, 64'(obs[42:40]), 64'(3'b100));
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, 64'(obs[42:40]), 64'(3'b000));
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_a", obs, 64'd0);
        sel = 1'b1;
        #1;
        check_eq("reset_b", obs, 64'd0);
        rst_n = 1'b1;

        // 8x4 instance: row stripes with inputs disturbed mid-fill, solid refills, random frames.
        run_frame("small_rowstripe", 8, 4, 2, 2, int'($urandom_range(255)), 100, 1'b1, -1);
        run_frame("small_solid5", 8, 4, 2, 0, 5, 100, 1'b0, -1);
        run_frame("small_solid2", 8, 4, 2, 0, 2, 100, 1'b0, -1);
        for (int i = 0; i < 6; i++)
            run_frame("small_rand", 8, 4, 2, int'($urandom_range(3)), int'($urandom_range(255)),
                      50, (i % 2) == 1, -1);

        // Default instance.
        sel = 1'b0;
        #1;
        run_frame("colstripe", 160, 120, 3, 1, 0, 100, 1'b0, -1);
        run_frame("checker2", 160, 120, 3, 3, 2, 100, 1'b0, -1);
        run_frame("abort", 160, 120, 3, 1, 0, 100, 1'b0, 40 * 120 + 60);
        rst_n = 1'b1;
        run_frame("restart_rand", 160, 120, 3, int'($urandom_range(3)), int'($urandom_range(7)),
                  50, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
